// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: round-robin sequencer for an ADC0804-class converter behind an
// analog multiplexer. It drives the cs_n/wr_n/rd_n handshake, waits for intr_n
// (with a timeout), and publishes each result with a one-cycle sample_valid.
// It also keeps a per-channel hysteresis flag against a common threshold.
//
// Optional feature: define ADC_AVG_EN to average four conversions per channel
// before publishing. Without it, every successful conversion is published raw.
//
// Handshake: sample_valid and timeout_err are single-cycle strobes with no
// back-pressure. sample_valid qualifies sample_data, sample_ch and the updated
// above[] bit in the same cycle. The two strobes are never high together.
module adc_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int N_CH    = 4,
  parameter int SETTLE  = 10,
  parameter int RD_WAIT = 2,
  parameter int TIMEOUT = 255,
  parameter int HYST    = 4,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              lcd_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              intr_n,
  input  logic [DATA_W-1:0] adata,
  input  logic [DATA_W-1:0] thresh,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic [CH_W-1:0]   ch_sel,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic [N_CH-1:0]   above,
  output logic              timeout_err
);

  // A single counter is shared by IDLE, WAIT and READ, so size it for the largest of the three.
  localparam int CNT_MAX_A = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > RD_WAIT + 1) ? CNT_MAX_A : RD_WAIT + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [DATA_W:0] HYST_V = (DATA_W + 1)'(HYST);
  localparam logic [DATA_W:0] MAX_V  = {1'b0, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d, ch_next;
  logic              conv_done;
  logic              conv_to;

  logic              pub_en;
  logic [DATA_W-1:0] pub_val;

  logic [DATA_W-1:0] sample_data_q;
  logic [CH_W-1:0]   sample_ch_q;
  logic              sample_valid_q;
  logic [N_CH-1:0]   above_q, above_d;
  logic              timeout_q;

  logic [DATA_W:0]   thr_sum;
  logic [DATA_W:0]   set_lvl;
  logic [DATA_W:0]   clr_lvl;
  logic [DATA_W:0]   pub_ext;

  // State, counter and channel registers; async reset parks the FSM in IDLE on ch0.
  always_ff @(posedge lcd_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
    end
  end

  // Next-state logic; conv_done marks the final READ edge, conv_to the WAIT abort edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    conv_done = 1'b0;
    conv_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (!intr_n) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          conv_to = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (cnt_q == CNT_W'(RD_WAIT)) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          conv_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel advances only when a conversion ends (success or abort), so ch_sel is stable through it.
  always_comb begin
    ch_next = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
    ch_d    = (conv_done || conv_to) ? ch_next : ch_q;
  end

  // Moore strobe decode from the registered state, so reset releases them immediately.
  always_comb begin
    cs_n = !((state_q == S_START) || (state_q == S_READ));
    wr_n = (state_q != S_START);
    rd_n = (state_q != S_READ);
  end

`ifdef ADC_AVG_EN
  logic [DATA_W+1:0] acc_q [N_CH];
  logic [1:0]        navg_q [N_CH];
  logic [DATA_W+1:0] acc_sum;

  // Running sum for the current channel; publish on the fourth good conversion.
  always_comb begin
    acc_sum = acc_q[ch_q] + {2'b00, adata};
    pub_en  = conv_done && (navg_q[ch_q] == 2'd3);
    pub_val = acc_sum[DATA_W+1:2];
  end

  // Per-channel accumulators: cleared on publish or timeout of that channel.
  always_ff @(posedge lcd_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i]  <= '0;
        navg_q[i] <= '0;
      end
    end else if (conv_to) begin
      acc_q[ch_q]  <= '0;
      navg_q[ch_q] <= '0;
    end else if (conv_done) begin
      if (navg_q[ch_q] == 2'd3) begin
        acc_q[ch_q]  <= '0;
        navg_q[ch_q] <= '0;
      end else begin
        acc_q[ch_q]  <= acc_sum;
        navg_q[ch_q] <= navg_q[ch_q] + 2'd1;
      end
    end
  end
`else
  // Without averaging, every successful conversion is published as captured.
  always_comb begin
    pub_en  = conv_done;
    pub_val = adata;
  end
`endif

  // Hysteresis levels in DATA_W+1 bits: set level saturates at full scale, clear level at zero.
  always_comb begin
    thr_sum = {1'b0, thresh} + HYST_V;
    set_lvl = (thr_sum > MAX_V) ? MAX_V : thr_sum;
    clr_lvl = ({1'b0, thresh} >= HYST_V) ? ({1'b0, thresh} - HYST_V) : '0;
    pub_ext = {1'b0, pub_val};
    above_d = above_q;
    if (pub_en) begin
      if (pub_ext >= set_lvl) begin
        above_d[ch_q] = 1'b1;
      end else if (pub_ext < clr_lvl) begin
        above_d[ch_q] = 1'b0;
      end
    end
  end

  // Published outputs: sample registers and flag update on the edge that leaves READ.
  always_ff @(posedge lcd_clk or negedge rst) begin
    if (!rst) begin
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      above_q        <= '0;
      timeout_q      <= 1'b0;
    end else begin
      sample_valid_q <= pub_en;
      timeout_q      <= conv_to;
      above_q        <= above_d;
      if (pub_en) begin
        sample_data_q <= pub_val;
        sample_ch_q   <= ch_q;
      end
    end
  end

  assign ch_sel       = ch_q;
  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign above        = above_q;
  assign timeout_err  = timeout_q;

endmodule
